// File: rtl/lsu_pkg.sv
// Shared encodings and decode helpers for the load/store master.
package lsu_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  // Access size in bytes (1/2/4) for the selected direction.
  function automatic logic [2:0] size(input logic we, input logic [2:0] lc, input logic [1:0] sc);
    logic [2:0] n;
    n = 3'd4;
    if (we) begin
      case (sc)
        SB:      n = 3'd1;
        SH:      n = 3'd2;
        default: n = 3'd4;
      endcase
    end else begin
      case (lc)
        LB, LBU: n = 3'd1;
        LH, LHU: n = 3'd2;
        default: n = 3'd4;
      endcase
    end
    return n;
  endfunction

  function automatic logic code_ok(input logic we, input logic [2:0] lc, input logic [1:0] sc);
    if (we) return sc != 2'b11;
    return lc inside {LB, LH, LW, LBU, LHU};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store mask/data placement and load merge/shift/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic        sext,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  mask,
  output logic [63:0] sdata,
  output logic [31:0] ldata
);

  logic [3:0]  base;
  logic [63:0] v;

  always_comb begin
    base = 4'hF;
    if (size == 3'd1)      base = 4'h1;
    else if (size == 3'd2) base = 4'h3;
  end

  // Two-word window so a split access sees both halves as one little-endian value.
  assign mask  = {4'b0, base} << off;
  assign sdata = {32'b0, wdata} << {off, 3'b000};
  assign v     = {hi, lo} >> {off, 3'b000};

  always_comb begin
    ldata = v[31:0];
    if (size == 3'd1)      ldata = {{24{sext & v[7]}}, v[7:0]};
    else if (size == 3'd2) ldata = {{16{sext & v[15]}}, v[15:0]};
  end

endmodule

// File: rtl/lsu_master.sv
// Data-memory initiator: one load/store at a time, split into up to two word beats.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [2:0]        load_code,
  input  logic [1:0]        store_code,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  state_t      state, nxt;
  logic        we_r, sext_r, split_r;
  logic [2:0]  size_r;
  logic [1:0]  off_r;
  logic [7:0]  mask_r;
  logic [63:0] sdata_r;
  logic [31:0] lo_r;

  logic [2:0]  cur_size;
  logic        cur_ok, cur_split, cur_sext;
  logic [2:0]  a_size;
  logic [1:0]  a_off;
  logic        a_sext;
  logic [31:0] a_lo, a_hi, a_ldata;
  logic [7:0]  a_mask;
  logic [63:0] a_sdata;

  assign cur_size  = size(cpu_we, load_code, store_code);
  assign cur_ok    = code_ok(cpu_we, load_code, store_code);
  assign cur_split = ({1'b0, cpu_addr[1:0]} + cur_size) > 3'd4;
  assign cur_sext  = (load_code == LB) || (load_code == LH);

  // In IDLE the lane logic decodes the incoming command; afterwards it merges load data.
  assign a_size = (state == IDLE) ? cur_size : size_r;
  assign a_off  = (state == IDLE) ? cpu_addr[1:0] : off_r;
  assign a_sext = sext_r;
  assign a_lo   = (state == BEAT0) ? mem_rdata : lo_r;
  assign a_hi   = (state == BEAT1) ? mem_rdata : 32'b0;

  lsu_align u_align (
    .size  (a_size),
    .off   (a_off),
    .wdata (cpu_wdata),
    .sext  (a_sext),
    .lo    (a_lo),
    .hi    (a_hi),
    .mask  (a_mask),
    .sdata (a_sdata),
    .ldata (a_ldata)
  );

  assign cpu_ready = (state == IDLE);
  assign cpu_done  = (state == RESP);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (cpu_valid) nxt = cur_ok ? BEAT0 : RESP;
      BEAT0: if (mem_ready) nxt = split_r ? BEAT1 : RESP;
      BEAT1: if (mem_ready) nxt = RESP;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_r      <= 1'b0;
      sext_r    <= 1'b0;
      split_r   <= 1'b0;
      size_r    <= 3'd0;
      off_r     <= 2'd0;
      mask_r    <= 8'd0;
      sdata_r   <= 64'd0;
      lo_r      <= 32'd0;
      cpu_rdata <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (cpu_valid) begin
          we_r    <= cpu_we;
          sext_r  <= ~cpu_we & cur_sext;
          split_r <= cur_split;
          size_r  <= cur_size;
          off_r   <= cpu_addr[1:0];
          mask_r  <= a_mask;
          sdata_r <= a_sdata;
          if (cur_ok) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr[ADDR_W-1:2];
            mem_be    <= a_mask[3:0];
            mem_wdata <= a_sdata[31:0];
          end else if (!cpu_we) begin
            cpu_rdata <= 32'd0;
          end
        end
        BEAT0: if (mem_ready) begin
          lo_r <= mem_rdata;
          if (split_r) begin
            mem_addr  <= mem_addr + 1'b1;
            mem_be    <= mask_r[7:4];
            mem_wdata <= sdata_r[63:32];
          end else begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!we_r) cpu_rdata <= a_ldata;
          end
        end
        BEAT1: if (mem_ready) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          if (!we_r) cpu_rdata <= a_ldata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Directed scoreboard bench: stimulus queues expected beats/responses, a monitor checks them.
module tb_lsu_master;
  import lsu_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_valid = 1'b0, cpu_we = 1'b0;
  logic [2:0]  load_code = 3'b0;
  logic [1:0]  store_code = 2'b0;
  logic [31:0] cpu_addr = 32'b0, cpu_wdata = 32'b0;
  logic        cpu_ready, cpu_done;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_rdata;

  logic [31:0] memarr [16];
  assign mem_rdata = memarr[mem_addr[3:0]];

  lsu_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .load_code(load_code), .store_code(store_code),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [29:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;} beat_t;
  typedef struct {logic [31:0] rdata; logic chk; int due;} resp_t;

  beat_t bq[$];
  resp_t rq[$];
  int total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Monitor: handshake stability plus scoreboard pops on beats and done pulses.
  logic        p_req = 1'b0, p_rdy = 1'b0, p_we = 1'b0, p_rst = 1'b0;
  logic [29:0] p_addr = '0;
  logic [3:0]  p_be = '0;
  logic [31:0] p_wd = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (p_rst && p_req && !p_rdy) begin
        check("hold_req", mem_req, 1'b1);
        check("hold_addr", mem_addr, p_addr);
        check("hold_be", mem_be, p_be);
        check("hold_we", mem_we, p_we);
        check("hold_wdata", mem_wdata, p_wd);
      end
      if (mem_req && mem_ready) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got addr %h want none", mem_addr);
        end else begin
          check("beat_addr", mem_addr, bq[0].addr);
          check("beat_be", mem_be, bq[0].be);
          check("beat_we", mem_we, bq[0].we);
          if (bq[0].we) check("beat_wdata", mem_wdata & bmask(mem_be), bq[0].wdata & bmask(bq[0].be));
          bq.delete(0);
        end
      end
      if (cpu_done) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done want none");
        end else begin
          if (rq[0].chk) check("rdata", cpu_rdata, rq[0].rdata);
          if (rq[0].due >= 0) check("done_cycle", cyc, rq[0].due);
          rq.delete(0);
        end
      end
    end
    p_rst  <= rst_n;
    p_req  <= mem_req;
    p_rdy  <= mem_ready;
    p_addr <= mem_addr;
    p_be   <= mem_be;
    p_we   <= mem_we;
    p_wd   <= mem_wdata;
  end

  task automatic pb(input logic [29:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    bq.push_back('{a, be, we, wd});
  endtask

  // lat: edges after acceptance until done (-1 = unchecked); exp_done=0 means no response expected.
  task automatic issue(input logic we, input logic [2:0] lc, input logic [1:0] sc,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input int lat, input logic exp_done);
    int n = 0;
    @(posedge clk); #1;
    while (!cpu_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cpu_ready) begin total++; bad++; $display("FAIL issue_timeout: got busy want ready"); end
    if (exp_done) rq.push_back('{exp_rd, !we, (lat >= 0) ? cyc + 1 + lat : -1});
    cpu_valid = 1'b1; cpu_we = we; load_code = lc; store_code = sc; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin @(posedge clk); n++; end
    if (rq.size() != 0 || bq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", rq.size() + bq.size());
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) memarr[i] = 32'h0;
    memarr[1] = 32'h80123456;
    memarr[2] = 32'hABCDEFFF;
    memarr[4] = 32'hDEADBEEF;
    memarr[5] = 32'h01234567;

    #12;
    check("rst_ready", cpu_ready, 1'b1);
    check("rst_done", cpu_done, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 30'h0);
    check("rst_be", mem_be, 4'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // aligned word load / byte store
    pb(30'h4, 4'hF, 1'b0, 32'h0);
    issue(1'b0, LW, SB, 32'h10, 32'h0, 32'hDEADBEEF, 1, 1'b1); drain();
    pb(30'h8, 4'b1000, 1'b1, 32'hA5000000);
    issue(1'b1, LB, SB, 32'h23, 32'h000000A5, 32'h0, 1, 1'b1); drain();

    // split halfword load, signed and unsigned
    pb(30'h1, 4'b1000, 1'b0, 32'h0); pb(30'h2, 4'b0001, 1'b0, 32'h0);
    issue(1'b0, LH, SB, 32'h07, 32'h0, 32'hFFFFFF80, 2, 1'b1); drain();
    pb(30'h1, 4'b1000, 1'b0, 32'h0); pb(30'h2, 4'b0001, 1'b0, 32'h0);
    issue(1'b0, LHU, SB, 32'h07, 32'h0, 32'h0000FF80, 2, 1'b1); drain();

    // split word store
    pb(30'h3, 4'b1100, 1'b1, 32'h33440000); pb(30'h4, 4'b0011, 1'b1, 32'h00001122);
    issue(1'b1, LB, SW, 32'h0E, 32'h11223344, 32'h0, 2, 1'b1); drain();

    // byte loads and split word load
    pb(30'h1, 4'b0010, 1'b0, 32'h0);
    issue(1'b0, LB, SB, 32'h05, 32'h0, 32'h00000034, 1, 1'b1); drain();
    pb(30'h1, 4'b1000, 1'b0, 32'h0);
    issue(1'b0, LB, SB, 32'h07, 32'h0, 32'hFFFFFF80, 1, 1'b1); drain();
    pb(30'h1, 4'b1000, 1'b0, 32'h0);
    issue(1'b0, LBU, SB, 32'h07, 32'h0, 32'h00000080, 1, 1'b1); drain();
    pb(30'h1, 4'b1100, 1'b0, 32'h0); pb(30'h2, 4'b0011, 1'b0, 32'h0);
    issue(1'b0, LW, SB, 32'h06, 32'h0, 32'hEFFF8012, 2, 1'b1); drain();

    // halfword store; split word store wrapping the word address
    pb(30'h0, 4'b1100, 1'b1, 32'hBEEF0000);
    issue(1'b1, LB, SH, 32'h02, 32'h0000BEEF, 32'h0, 1, 1'b1); drain();
    pb(30'h3FFFFFFF, 4'b1110, 1'b1, 32'hBBCCDD00); pb(30'h0, 4'b0001, 1'b1, 32'h000000AA);
    issue(1'b1, LB, SW, 32'hFFFFFFFD, 32'hAABBCCDD, 32'h0, 2, 1'b1); drain();

    // stall: outputs held, cpu_valid ignored while busy
    mem_ready = 1'b0;
    pb(30'h5, 4'hF, 1'b0, 32'h0);
    issue(1'b0, LW, SB, 32'h14, 32'h0, 32'h01234567, -1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", cpu_ready, 1'b0);
      cpu_valid = 1'b1; cpu_we = 1'b1; store_code = SB; cpu_addr = 32'h0;
      @(posedge clk); #1;
    end
    cpu_valid = 1'b0; mem_ready = 1'b1;
    drain();

    // reset during second beat of a split store
    pb(30'h3, 4'b1100, 1'b1, 32'h33440000);
    issue(1'b1, LB, SW, 32'h0E, 32'h11223344, 32'h0, 2, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_ready", cpu_ready, 1'b1);
    check("rst_mid_done", cpu_done, 1'b0);
    check("rst_mid_rdata", cpu_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("rst_mid_beats_left", bq.size(), 0);
    bq.delete();

    // invalid codes: no traffic, done next cycle, loads return zero
    memarr[4] = 32'hFFFFFFFF;
    pb(30'h4, 4'hF, 1'b0, 32'h0);
    issue(1'b0, LW, SB, 32'h10, 32'h0, 32'hFFFFFFFF, 1, 1'b1); drain();
    issue(1'b0, 3'b011, SB, 32'h10, 32'h0, 32'h0, 0, 1'b1); drain();
    issue(1'b1, LB, 2'b11, 32'h10, 32'h12345678, 32'h0, 0, 1'b1); drain();

    check("queues_empty", bq.size() + rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
